// File: rtl/cursor_pkg.sv
// cursor_pkg: shared types and constants for mouse_cursor_tracker.
//  ms_state_t  packet-assembly FSM states
//  BIT_*       byte0 field positions of a PS/2 mouse packet
//  POS_W       cursor coordinate width
//  DLT_W       width of the effective (optionally scaled) delta
//  scale_delta returns the effective delta, doubled when scaling is enabled
//              and |d| exceeds the threshold
package cursor_pkg;

  typedef enum logic [1:0] {B0, B1, B2, UPD} ms_state_t;

  localparam int BIT_SYNC = 3;
  localparam int BIT_XS   = 4;
  localparam int BIT_YS   = 5;
  localparam int BIT_XO   = 6;
  localparam int BIT_YO   = 7;
  localparam int POS_W    = 11;
  localparam int DLT_W    = 12;

  function automatic logic [DLT_W-1:0] scale_delta(input logic signed [8:0] d,
                                                   input int th,
                                                   input bit en);
    int v;
    v = int'(d);
    if (en && (v > th || v < -th)) return 12'(2 * v);
    return 12'(v);
  endfunction

endpackage

// File: rtl/mouse_cursor_tracker_axis_step.sv
// axis_step: combinational single-axis cursor step with clamp.
//  pos       in   current position (unsigned)
//  delta     in   signed effective delta
//  neg       in   1: subtract delta (screen Y grows downward), 0: add
//  max       in   largest legal position
//  next_pos  out  new position clamped to 0..max
module axis_step
  import cursor_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [DLT_W-1:0] delta,
  input  logic             neg,
  input  logic [POS_W-1:0] max,
  output logic [POS_W-1:0] next_pos
);

  logic signed [12:0] p;
  logic signed [12:0] d;
  logic signed [12:0] m;
  logic signed [12:0] s;

  always_comb begin
    p        = signed'({2'b00, pos});
    d        = signed'({delta[DLT_W-1], delta});
    m        = signed'({2'b00, max});
    s        = neg ? (p - d) : (p + d);
    next_pos = s[POS_W-1:0];
    if (s < 0)
      next_pos = '0;
    else if (s > m)
      next_pos = max;
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: assembles 3-byte PS/2 mouse packets and keeps an
// absolute, screen-clamped cursor position plus button state.
//  clk       in   system clock
//  reset_n   in   synchronous active-low reset
//  rx_data   in   byte from the PS/2 receiver
//  rx_valid  in   1-cycle strobe qualifying rx_data
//  cursorX   out  cursor column 0..W-1
//  cursorY   out  cursor row 0..H-1, 0 = top
//  buttons   out  {middle,right,left} from the last packet
//  pkt_done  out  1-cycle pulse when position/buttons update
//  sync_err  out  1-cycle pulse when a byte is dropped waiting for byte 0
// Build option: define CURSOR_ACCEL_EN to double deltas whose magnitude
// exceeds ACC_TH.
//
// state | meaning
// B0    | waiting for byte 0 (bit 3 must be set, otherwise byte dropped)
// B1    | waiting for X delta byte
// B2    | waiting for Y delta byte
// UPD   | one cycle: register clamped position and buttons, pulse pkt_done
module mouse_cursor_tracker
  import cursor_pkg::*;
#(
  parameter int W      = 640,
  parameter int H      = 480,
  parameter int ACC_TH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] cursorX,
  output logic [POS_W-1:0] cursorY,
  output logic [2:0]       buttons,
  output logic             pkt_done,
  output logic             sync_err
);

`ifdef CURSOR_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam logic [POS_W-1:0] X_MAX = POS_W'(W - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(H - 1);
  localparam logic [POS_W-1:0] X_RST = POS_W'(W / 2);
  localparam logic [POS_W-1:0] Y_RST = POS_W'(H / 2);

  ms_state_t         state;
  logic [2:0]        lat_btn;
  logic              lat_xs, lat_ys, lat_xo, lat_yo;
  logic [7:0]        dx_lo, dy_lo;
  logic signed [8:0] dx9, dy9;
  logic [DLT_W-1:0]  dx_eff, dy_eff;
  logic [POS_W-1:0]  nx, ny;

  // overflowed axes contribute no movement
  assign dx9    = lat_xo ? 9'sd0 : signed'({lat_xs, dx_lo});
  assign dy9    = lat_yo ? 9'sd0 : signed'({lat_ys, dy_lo});
  assign dx_eff = scale_delta(dx9, ACC_TH, ACCEL_ON);
  assign dy_eff = scale_delta(dy9, ACC_TH, ACCEL_ON);

  axis_step u_step_x (
    .pos      (cursorX),
    .delta    (dx_eff),
    .neg      (1'b0),
    .max      (X_MAX),
    .next_pos (nx)
  );

  // mouse +Y is up, screen +Y is down
  axis_step u_step_y (
    .pos      (cursorY),
    .delta    (dy_eff),
    .neg      (1'b1),
    .max      (Y_MAX),
    .next_pos (ny)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= B0;
      cursorX  <= X_RST;
      cursorY  <= Y_RST;
      buttons  <= '0;
      pkt_done <= 1'b0;
      sync_err <= 1'b0;
      lat_btn  <= '0;
      lat_xs   <= 1'b0;
      lat_ys   <= 1'b0;
      lat_xo   <= 1'b0;
      lat_yo   <= 1'b0;
      dx_lo    <= '0;
      dy_lo    <= '0;
    end else begin
      pkt_done <= 1'b0;
      sync_err <= 1'b0;
      case (state)
        B0: if (rx_valid) begin
          if (rx_data[BIT_SYNC]) begin
            lat_btn <= rx_data[2:0];
            lat_xs  <= rx_data[BIT_XS];
            lat_ys  <= rx_data[BIT_YS];
            lat_xo  <= rx_data[BIT_XO];
            lat_yo  <= rx_data[BIT_YO];
            state   <= B1;
          end else begin
            sync_err <= 1'b1;
          end
        end
        B1: if (rx_valid) begin
          dx_lo <= rx_data;
          state <= B2;
        end
        B2: if (rx_valid) begin
          dy_lo <= rx_data;
          state <= UPD;
        end
        UPD: begin
          cursorX  <= nx;
          cursorY  <= ny;
          buttons  <= lat_btn;
          pkt_done <= 1'b1;
          state    <= B0;
        end
        default: state <= B0;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
module tb_mouse_cursor_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] cursorX, cursorY;
  logic [2:0]  buttons;
  logic        pkt_done, sync_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mx, my, mb;

  mouse_cursor_tracker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cursorX  (cursorX),
    .cursorY  (cursorY),
    .buttons  (buttons),
    .pkt_done (pkt_done),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // movement along one axis from the packet's sign/overflow flags and byte
  function automatic int axis_move(input bit sgn, input bit ovf, input logic [7:0] mag);
    int d;
    if (ovf) return 0;
    d = int'(mag);
    if (sgn) d = d - 256;
`ifdef CURSOR_ACCEL_EN
    if (d > 16 || d < -16) d = d * 2;
`endif
    return d;
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b1;          // reset must win over a concurrent strobe
    rx_data  = 8'h08;
    @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    mx = 320; my = 240; mb = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int exp_sync);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check_val("sync_err", int'(sync_err), exp_sync);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input bit poke_upd);
    logic [7:0] h;
    h = b0;
    send_byte(b0, 0);
    gap();
    send_byte(b1, 0);
    gap();
    send_byte(b2, 0);
    check_val("pkt_done_early", int'(pkt_done), 0);
    mx = clampi(mx + axis_move(h[4], h[6], b1), 639);
    my = clampi(my - axis_move(h[5], h[7], b2), 479);
    mb = int'(h[2:0]);
    if (poke_upd) begin
      // byte arriving during the update cycle must be ignored
      rx_data  = 8'h00;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check_val("pkt_done", int'(pkt_done), 1);
    check_val("cursorX", int'(cursorX), mx);
    check_val("cursorY", int'(cursorY), my);
    check_val("buttons", int'(buttons), mb);
    check_val("sync_err_upd", int'(sync_err), 0);
    @(negedge clk);
    check_val("pkt_done_pulse", int'(pkt_done), 0);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    do_reset();

    // reset state and idle hold
    repeat (4) @(negedge clk);
    check_val("rst_x", int'(cursorX), 320);
    check_val("rst_y", int'(cursorY), 240);
    check_val("rst_btn", int'(buttons), 0);
    check_val("rst_pd", int'(pkt_done), 0);
    check_val("rst_se", int'(sync_err), 0);

    // simple move
    send_packet(8'h08, 8'h0A, 8'h05, 1'b0);
    check_val("t2_x", int'(cursorX), 330);
    check_val("t2_y", int'(cursorY), 235);

    // push into the bottom-left corner and beyond
    do_reset();
    repeat (3) send_packet(8'h38, 8'h80, 8'h80, 1'b0);
    check_val("t3_x", int'(cursorX), 0);
    check_val("t3_y", int'(cursorY), 479);
    send_packet(8'h38, 8'h80, 8'h80, 1'b0);
    check_val("t3_x_hold", int'(cursorX), 0);
    check_val("t3_y_hold", int'(cursorY), 479);

    // stray byte then a button-only packet
    do_reset();
    send_byte(8'h00, 1);
    @(negedge clk);
    check_val("t4_se_pulse", int'(sync_err), 0);
    send_packet(8'h09, 8'h00, 8'h00, 1'b0);
    check_val("t4_btn", int'(buttons), 1);
    check_val("t4_x", int'(cursorX), 320);
    check_val("t4_y", int'(cursorY), 240);

    // X overflow
    send_packet(8'h48, 8'hFF, 8'h02, 1'b0);
    check_val("t5_x", int'(cursorX), 320);
    check_val("t5_y", int'(cursorY), 238);
`ifdef CURSOR_ACCEL_EN
    send_packet(8'h08, 8'h14, 8'h00, 1'b0);
    check_val("t5_accel_x", int'(cursorX), 360);
`endif

    // reset mid-packet discards the partial packet
    do_reset();
    send_byte(8'h08, 0);
    send_byte(8'h05, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mx = 320; my = 240; mb = 0;
    send_packet(8'h08, 8'h01, 8'h00, 1'b0);
    check_val("t6_x", int'(cursorX), 321);
    check_val("t6_y", int'(cursorY), 240);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r0 = 8'($urandom) & 8'hF7;
        send_byte(r0, 1);
      end
      r0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 3) != 0) r0 = r0 & 8'h3F;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_packet(r0, r1, r2, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
